// File: rtl/perf_stage_gen.sv
// Six-stage strobe sequencer: programmable run length and gap per stage, an
// F2G echo of the stream valid delayed by F2G_LAT, then drain, readback, done.
module perf_stage_gen #(
  parameter int CNT_W   = 16,
  parameter int F2G_LAT = 4
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RESET,
  input  logic             START,
  input  logic             CFG_WR,
  input  logic [3:0]       CFG_ADDR,
  input  logic [CNT_W-1:0] CFG_DATA,
  output logic             PROC_WR_EN,
  output logic             IF_CFG_WR_EN,
  output logic             CGRA_CFG_G2F_CFG_WR_EN,
  output logic             STREAM_DATA_VALID_G2F,
  output logic             STREAM_DATA_VALID_F2G,
  output logic             PROC_RD_EN,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT, ST_GAP, ST_DRAIN, ST_RDBK, ST_FIN
  } state_t;

  // Phases 0..11 interleave ACT(s)/GAP(s); PHASE_END means all stages are done.
  localparam logic [3:0] PHASE_END = 4'd12;

  state_t           state_r, state_nxt_s, jump_state_s;
  logic [2:0]       stage_r, stage_nxt_s, jump_stage_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, jump_cnt_s, post_cnt_r;
  logic [CNT_W-1:0] len_r [6];
  logic [CNT_W-1:0] gap_r [6];
  logic [CNT_W-1:0] len_eff_s [6];
  logic [CNT_W-1:0] gap_eff_s [6];
  logic [11:0]      nz_s;
  logic [3:0]       cur_phase_s, from_phase_s, next_phase_s;
  logic             cfg_we_s, pending_s, gap_ok_s, drain_ok_s;

  function automatic logic [3:0] find_phase(input logic [11:0] nz, input logic [3:0] from);
    logic [3:0] r;
    r = PHASE_END;
    for (int i = 11; i >= 0; i--) begin
      if ((i >= int'(from)) && nz[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign cfg_we_s = CFG_WR && (state_r == ST_IDLE);

  // Register file with the same-edge write overlaid, so a START coinciding with a write sees the new value.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      len_eff_s[i] = len_r[i];
      gap_eff_s[i] = gap_r[i];
    end
    case (cfg_we_s ? CFG_ADDR : 4'd15)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5:       len_eff_s[CFG_ADDR[2:0]] = CFG_DATA;
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13:   gap_eff_s[CFG_ADDR[2:0]] = CFG_DATA;
      default: begin end
    endcase
    for (int i = 0; i < 6; i++) begin
      nz_s[2*i]   = |len_eff_s[i];
      nz_s[2*i+1] = |gap_eff_s[i];
    end
  end

  // Config registers: writes land only in IDLE.
  always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      for (int i = 0; i < 6; i++) begin
        len_r[i] <= CNT_W'(1);
        gap_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        len_r[i] <= len_eff_s[i];
        gap_r[i] <= gap_eff_s[i];
      end
    end
  end

  generate
    if (F2G_LAT == 0) begin : g_no_delay
      assign STREAM_DATA_VALID_F2G = STREAM_DATA_VALID_G2F;
      assign pending_s             = 1'b0;
    end else begin : g_delay
      logic [F2G_LAT-1:0] dly_r;
      logic [F2G_LAT:0]   chain_s;
      assign chain_s               = {dly_r, STREAM_DATA_VALID_G2F};
      // Anything upstream of the last stage will still show up on F2G later.
      assign pending_s             = |chain_s[F2G_LAT-1:0];
      assign STREAM_DATA_VALID_F2G = dly_r[F2G_LAT-1];

      // F2G delay line.
      always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
          dly_r <= {F2G_LAT{1'b0}};
        end else begin
          dly_r <= chain_s[F2G_LAT-1:0];
        end
      end
    end
  endgenerate

  // Cycles of GAP[6] still owed after the most recent F2G beat.
  always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      post_cnt_r <= {CNT_W{1'b0}};
    end else if (STREAM_DATA_VALID_F2G) begin
      post_cnt_r <= gap_r[5];
    end else if (post_cnt_r != {CNT_W{1'b0}}) begin
      post_cnt_r <= post_cnt_r - CNT_W'(1);
    end else begin
      post_cnt_r <= post_cnt_r;
    end
  end

  assign gap_ok_s   = STREAM_DATA_VALID_F2G ? (gap_r[5] == {CNT_W{1'b0}})
                                            : (post_cnt_r <= CNT_W'(1));
  assign drain_ok_s = !pending_s && gap_ok_s;

  // Next-state: zero-length phases are skipped within the same cycle.
  always_comb begin
    cur_phase_s  = {stage_r - 3'd1, state_r == ST_GAP};
    from_phase_s = (state_r == ST_IDLE) ? 4'd0 : cur_phase_s + 4'd1;
    next_phase_s = find_phase(nz_s, from_phase_s);
    if (next_phase_s == PHASE_END) begin
      jump_state_s = drain_ok_s ? ST_RDBK : ST_DRAIN;
      jump_stage_s = stage_r;
      jump_cnt_s   = {CNT_W{1'b0}};
    end else begin
      jump_state_s = next_phase_s[0] ? ST_GAP : ST_ACT;
      jump_stage_s = next_phase_s[3:1] + 3'd1;
      jump_cnt_s   = next_phase_s[0] ? gap_eff_s[next_phase_s[3:1]] : len_eff_s[next_phase_s[3:1]];
    end
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_nxt_s = jump_state_s;
          stage_nxt_s = jump_stage_s;
          cnt_nxt_s   = jump_cnt_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACT, ST_GAP: begin
        if (cnt_r > CNT_W'(1)) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          state_nxt_s = jump_state_s;
          stage_nxt_s = jump_stage_s;
          cnt_nxt_s   = jump_cnt_s;
        end
      end
      ST_DRAIN: state_nxt_s = drain_ok_s ? ST_RDBK : ST_DRAIN;
      ST_RDBK:  state_nxt_s = ST_FIN;
      ST_FIN:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and outputs, registered from the next state so they align with it.
  always_ff @(posedge CPU_CLK or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state_r                <= ST_IDLE;
      stage_r                <= 3'd0;
      cnt_r                  <= {CNT_W{1'b0}};
      PROC_WR_EN             <= 1'b0;
      IF_CFG_WR_EN           <= 1'b0;
      CGRA_CFG_G2F_CFG_WR_EN <= 1'b0;
      STREAM_DATA_VALID_G2F  <= 1'b0;
      PROC_RD_EN             <= 1'b0;
      BUSY                   <= 1'b0;
      DONE                   <= 1'b0;
    end else begin
      state_r                <= state_nxt_s;
      stage_r                <= stage_nxt_s;
      cnt_r                  <= cnt_nxt_s;
      PROC_WR_EN             <= (state_nxt_s == ST_ACT) && ((stage_nxt_s == 3'd1) || (stage_nxt_s == 3'd4));
      IF_CFG_WR_EN           <= (state_nxt_s == ST_ACT) && ((stage_nxt_s == 3'd2) || (stage_nxt_s == 3'd5));
      CGRA_CFG_G2F_CFG_WR_EN <= (state_nxt_s == ST_ACT) && (stage_nxt_s == 3'd3);
      STREAM_DATA_VALID_G2F  <= (state_nxt_s == ST_ACT) && (stage_nxt_s == 3'd6);
      PROC_RD_EN             <= (state_nxt_s == ST_RDBK);
      BUSY                   <= (state_nxt_s == ST_ACT) || (state_nxt_s == ST_GAP) ||
                                (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_RDBK);
      DONE                   <= (state_nxt_s == ST_FIN);
    end
  end

endmodule

// File: tb/tb_perf_stage_gen.sv
// Scoreboard bench for perf_stage_gen: expected per-cycle output vectors are
// derived from the programmed lengths/gaps and compared each cycle.
module tb_perf_stage_gen;
  localparam int CNT_W = 8;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cfg_wr = 1'b0;
  logic [3:0] cfg_addr = 4'd0;
  logic [CNT_W-1:0] cfg_data = 8'd0;
  logic proc_wr, if_wr, cgra_wr, g2f, f2g, rd_en, busy, done;
  logic [7:0] outs_s;

  // {BUSY, DONE, PROC_RD_EN, F2G, G2F, CGRA, IF, PROC}
  assign outs_s = {busy, done, rd_en, f2g, g2f, cgra_wr, if_wr, proc_wr};

  int m_len [6];
  int m_gap [6];
  logic [7:0] ev [0:2047];
  logic [7:0] sb_q [$];
  int n_pass = 0;
  int n_total = 0;

  perf_stage_gen #(.CNT_W(CNT_W), .F2G_LAT(LAT)) dut (
    .CPU_CLK(clk), .CPU_RESET(rst), .START(start), .CFG_WR(cfg_wr),
    .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data),
    .PROC_WR_EN(proc_wr), .IF_CFG_WR_EN(if_wr), .CGRA_CFG_G2F_CFG_WR_EN(cgra_wr),
    .STREAM_DATA_VALID_G2F(g2f), .STREAM_DATA_VALID_F2G(f2g),
    .PROC_RD_EN(rd_en), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic model_defaults();
    for (int i = 0; i < 6; i++) begin
      m_len[i] = 1;
      m_gap[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_defaults();
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (a < 4'd6) m_len[a] = int'(d);
    else if (a >= 4'd8 && a < 4'd14) m_gap[a - 4'd8] = int'(d);
  endtask

  // Expected waveform, cycle 1 = first cycle after the START edge; three idle cycles appended.
  task automatic push_expected();
    int t, g0, rd, bitn;
    for (int c = 0; c < 2048; c++) ev[c] = 8'h00;
    t = 1; g0 = 0;
    for (int s = 0; s < 6; s++) begin
      bitn = (s == 0 || s == 3) ? 0 : (s == 1 || s == 4) ? 1 : (s == 2) ? 2 : 3;
      if (s == 5) g0 = t;
      for (int k = 0; k < m_len[s]; k++) begin
        ev[t+k][bitn] = 1'b1;
        if (s == 5) ev[t+k+LAT][4] = 1'b1;
      end
      t += m_len[s] + m_gap[s];
    end
    rd = t;
    if (m_len[5] > 0 && (g0 + m_len[5] + LAT + m_gap[5]) > rd) rd = g0 + m_len[5] + LAT + m_gap[5];
    for (int c = 1; c <= rd; c++) ev[c][7] = 1'b1;
    ev[rd][5] = 1'b1;
    ev[rd+1][6] = 1'b1;
    for (int c = 1; c <= rd + 3; c++) sb_q.push_back(ev[c]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (outs_s !== 8'h00) $display("FAIL reset_state: got %b want %b", outs_s, 8'h00);
    else n_pass++;
    rst = 1'b0;
    model_defaults();
    repeat (4) begin
      @(negedge clk);
      n_total++;
      if (outs_s !== 8'h00) $display("FAIL reset_idle: got %b want %b", outs_s, 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_defaults();
    int cyc;
    logic [7:0] exp_v;
    push_expected();
    @(negedge clk); start = 1'b1;
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL defaults cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_pattern();
    int cyc;
    logic [7:0] exp_v;
    int lens [6] = '{10, 4, 8, 10, 4, 6};
    int gaps [6] = '{3, 2, 5, 1, 2, 7};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cfg_write(4'(i), 8'(lens[i]));
      cfg_write(4'(i + 8), 8'(gaps[i]));
    end
    push_expected();
    @(negedge clk); start = 1'b1;
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL pattern cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_zero_len();
    int cyc;
    logic [7:0] exp_v;
    do_reset();
    cfg_write(4'd1, 8'd3);
    cfg_write(4'd8, 8'd2);
    cfg_write(4'd2, 8'd0);
    cfg_write(4'd9, 8'd0);
    cfg_write(4'd10, 8'd0);
    push_expected();
    @(negedge clk); start = 1'b1;
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL zero_len cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_cfg_with_start();
    int cyc;
    logic [7:0] exp_v;
    do_reset();
    cfg_write(4'd7, 8'd50);
    cfg_write(4'd15, 8'd50);
    m_len[0] = 2;
    push_expected();
    @(negedge clk); start = 1'b1; cfg_wr = 1'b1; cfg_addr = 4'd0; cfg_data = 8'd2;
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cfg_wr = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL cfg_with_start cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    logic [7:0] exp_v;
    do_reset();
    cfg_write(4'd0, 8'd3);
    for (int r = 0; r < 2; r++) begin
      push_expected();
      @(negedge clk); start = 1'b1;
      cyc = 1;
      while (sb_q.size() > 0) begin
        @(negedge clk); start = 1'b0; cfg_wr = 1'b0;
        exp_v = sb_q.pop_front();
        n_total++;
        if (outs_s !== exp_v) $display("FAIL busy_ignore run %0d cyc %0d: got %b want %b", r, cyc, outs_s, exp_v);
        else n_pass++;
        if (r == 0 && cyc == 3) begin
          start = 1'b1; cfg_wr = 1'b1; cfg_addr = 4'd0; cfg_data = 8'd9;
        end
        cyc++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] exp_v;
    do_reset();
    cfg_write(4'd3, 8'd6);
    push_expected();
    @(negedge clk); start = 1'b1;
    for (cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL reset_mid_pre cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
    end
    sb_q.delete();
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (outs_s !== 8'h00) $display("FAIL reset_mid_async: got %b want %b", outs_s, 8'h00);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    model_defaults();
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (outs_s !== 8'h00) $display("FAIL reset_mid_idle: got %b want %b", outs_s, 8'h00);
      else n_pass++;
    end
    push_expected();
    @(negedge clk); start = 1'b1;
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL reset_mid_replay cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_max_len();
    int cyc;
    logic [7:0] exp_v;
    do_reset();
    cfg_write(4'd5, 8'd255);
    cfg_write(4'd13, 8'd2);
    push_expected();
    @(negedge clk); start = 1'b1;
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk); start = 1'b0;
      exp_v = sb_q.pop_front();
      n_total++;
      if (outs_s !== exp_v) $display("FAIL max_len cyc %0d: got %b want %b", cyc, outs_s, exp_v);
      else n_pass++;
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_pattern();
    test_zero_len();
    test_cfg_with_start();
    test_busy_ignore();
    test_reset_mid();
    test_max_len();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
